// File: rtl/adxl362_sample_ctrl_if.sv
// Byte-level SPI master handshake between the ADXL362 sequencer
// and the shift engine that drives the pins.
interface adxl362_sample_ctrl_if;
    logic       spi_start;
    logic [7:0] spi_tx;
    logic       spi_done;
    logic [7:0] spi_rx;

    modport master (
        output spi_start,
        output spi_tx,
        input  spi_done,
        input  spi_rx
    );

    modport slave (
        input  spi_start,
        input  spi_tx,
        output spi_done,
        output spi_rx
    );
endinterface

// File: rtl/adxl362_sample_ctrl.sv
// ADXL362 burst-read sequencer: triggers a 6-byte XYZ read over the
// byte SPI master and publishes the result as three atomic words.
module adxl362_sample_ctrl #(
    parameter int unsigned SAMPLE_DIV   = 100000,
    parameter int unsigned CS_SETUP_CYC = 4,
    parameter logic [7:0]  CMD_READ     = 8'h0B,
    parameter logic [7:0]  START_ADDR   = 8'h0E
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        trig_mode,
    input  logic        sw_req,
    input  logic        int1,
    adxl362_sample_ctrl_if.master spi,
    output logic        ncs_o,
    output logic [15:0] x_data,
    output logic [15:0] y_data,
    output logic [15:0] z_data,
    output logic        sample_valid,
    output logic [15:0] sample_count,
    output logic        busy,
    output logic        overrun,
    input  logic        overrun_clr
);

    localparam int TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(CS_SETUP_CYC + 1);
    localparam logic [TW-1:0] TIMER_RLD = TW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CS_RLD    = CW'(CS_SETUP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CS_HOLD,
        S_UPDATE
    } state_t;

    state_t state_q, state_d;

    logic          int1_s1, int1_s2, int1_s3;
    logic          int1_rise;
    logic [TW-1:0] timer;
    logic          timer_run;
    logic          tick;
    logic          trig;
    logic          pending;
    logic          launch;
    logic          issued;
    logic          wait_done;
    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic [2:0]    idx;
    logic          idx_last;
    logic [7:0]    shadow [6];

    assign int1_rise = int1_s2 & ~int1_s3;
    assign timer_run = enable & ~trig_mode;
    assign tick      = timer_run & (timer == '0);
    assign trig      = enable & (sw_req | (trig_mode ? int1_rise : tick));
    assign launch    = (state_q == S_IDLE) & pending;
    assign wait_done = issued & spi.spi_done;
    assign cnt_zero  = (cnt == '0);
    assign idx_last  = (idx == 3'd5);
    assign busy      = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int1_s1 <= 1'b0;
            int1_s2 <= 1'b0;
            int1_s3 <= 1'b0;
        end else begin
            int1_s1 <= int1;
            int1_s2 <= int1_s1;
            int1_s3 <= int1_s2;
        end
    end

    // Timer sits at its reload value whenever periodic mode is idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= TIMER_RLD;
        end else if (!timer_run || timer == '0) begin
            timer <= TIMER_RLD;
        end else begin
            timer <= timer - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (!enable) begin
                pending <= 1'b0;
            end else if (launch) begin
                pending <= trig;
            end else if (trig) begin
                pending <= 1'b1;
            end
            if (trig && pending && !launch) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        spi.spi_start = 1'b0;
        spi.spi_tx    = 8'h00;
        unique case (state_q)
            S_IDLE: begin
                if (pending) state_d = S_CS_SETUP;
            end
            S_CS_SETUP: begin
                if (cnt_zero) state_d = S_CMD;
            end
            S_CMD: begin
                spi.spi_start = ~issued;
                spi.spi_tx    = CMD_READ;
                if (wait_done) state_d = S_ADDR;
            end
            S_ADDR: begin
                spi.spi_start = ~issued;
                spi.spi_tx    = START_ADDR;
                if (wait_done) state_d = S_DATA;
            end
            S_DATA: begin
                spi.spi_start = ~issued;
                if (wait_done && idx_last) state_d = S_CS_HOLD;
            end
            S_CS_HOLD: begin
                if (cnt_zero) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // issued marks the wait phase of a byte; done pulses outside it are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued <= 1'b0;
        end else if (spi.spi_start) begin
            issued <= 1'b1;
        end else if (wait_done) begin
            issued <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            ncs_o <= 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        cnt   <= CS_RLD;
                        ncs_o <= 1'b0;
                    end
                end
                S_CS_SETUP: begin
                    if (!cnt_zero) cnt <= cnt - 1'b1;
                end
                S_DATA: begin
                    if (wait_done && idx_last) cnt <= CS_RLD;
                end
                S_CS_HOLD: begin
                    if (cnt_zero) begin
                        ncs_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
            for (int i = 0; i < 6; i++) shadow[i] <= '0;
        end else begin
            if (state_q == S_ADDR && wait_done) begin
                idx <= '0;
            end
            if (state_q == S_DATA && wait_done) begin
                shadow[idx] <= spi.spi_rx;
                if (!idx_last) idx <= idx + 1'b1;
            end
        end
    end

    // Published words only move here, so readers never see a mixed sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_data       <= '0;
            y_data       <= '0;
            z_data       <= '0;
            sample_valid <= 1'b0;
            sample_count <= '0;
        end else begin
            sample_valid <= (state_q == S_UPDATE);
            if (state_q == S_UPDATE) begin
                x_data       <= {shadow[1], shadow[0]};
                y_data       <= {shadow[3], shadow[2]};
                z_data       <= {shadow[5], shadow[4]};
                sample_count <= sample_count + 1'b1;
            end
        end
    end

endmodule
